// File: rtl/addsub_datapath_if.sv
// Bus bundle between the add/subtract control unit and its datapath stage.
// Signal prefixes follow the datapath's point of view.
interface addsub_datapath_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [5:0]       i_cs;
    logic [WIDTH-1:0] i_dataA;
    logic [WIDTH-1:0] i_dataB;
    logic [WIDTH-1:0] o_acc;
    logic             o_carry;
    logic             o_zero;
    logic [WIDTH-1:0] o_result;
    logic             o_resultValid;
    logic [CNT_W-1:0] o_opCount;
    logic             o_ovf;

    modport master (
        output i_cs, i_dataA, i_dataB,
        input  o_acc, o_carry, o_zero, o_result, o_resultValid, o_opCount, o_ovf
    );

    modport slave (
        input  i_cs, i_dataA, i_dataB,
        output o_acc, o_carry, o_zero, o_result, o_resultValid, o_opCount, o_ovf
    );
endinterface

// File: rtl/addsub_datapath.sv
// Add/subtract datapath: RA/RB/ACC registers, flags, done-edge result capture.
// Define ADDSUB_OVF_FLAG_EN to build the signed overflow flag; otherwise ovf is tied to 0.
module addsub_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic              clock,
    input logic              reset,
    addsub_datapath_if.slave bus
);
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_opCount;
    logic             r_carry;
    logic             r_zero;
    logic             r_resultValid;
    logic             r_doneQ;

    logic             w_en;
    logic             w_done;
    logic [2:0]       w_sel;
    logic             w_m;
    logic             w_isArith;
    logic             w_isClear;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_yEff;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_accNext;
    logic             w_doneEdge;

    // Subtraction is X + ~Y + 1, so carry out means "no borrow".
    always_comb begin
        w_en       = bus.i_cs[5];
        w_done     = bus.i_cs[4];
        w_sel      = bus.i_cs[3:1];
        w_m        = bus.i_cs[0];
        w_isArith  = w_en && (w_sel == 3'b011 || w_sel == 3'b100 || w_sel == 3'b101);
        w_isClear  = w_en && (w_sel == 3'b110);
        w_x        = (w_sel == 3'b011) ? r_ra : r_acc;
        w_y        = (w_sel == 3'b101) ? r_ra : r_rb;
        w_yEff     = w_m ? ~w_y : w_y;
        w_sum      = {1'b0, w_x} + {1'b0, w_yEff} + {{WIDTH{1'b0}}, w_m};
        w_accNext  = r_acc;
        if (w_isArith) begin
            w_accNext = w_sum[WIDTH-1:0];
        end else if (w_isClear) begin
            w_accNext = '0;
        end
        w_doneEdge = w_done && !r_doneQ;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ra          <= '0;
            r_rb          <= '0;
            r_acc         <= '0;
            r_result      <= '0;
            r_opCount     <= '0;
            r_carry       <= 1'b0;
            r_zero        <= 1'b0;
            r_resultValid <= 1'b0;
            r_doneQ       <= 1'b0;
        end else begin
            r_doneQ       <= w_done;
            r_resultValid <= w_doneEdge;
            r_acc         <= w_accNext;
            if (w_doneEdge) begin
                r_result <= w_accNext;
            end
            if (w_en && w_sel == 3'b001) begin
                r_ra <= bus.i_dataA;
            end
            if (w_en && w_sel == 3'b010) begin
                r_rb <= bus.i_dataB;
            end
            if (w_isArith) begin
                r_carry <= w_sum[WIDTH];
                r_zero  <= (w_sum[WIDTH-1:0] == '0);
                if (r_opCount != {CNT_W{1'b1}}) begin
                    r_opCount <= r_opCount + CNT_W'(1);
                end
            end else if (w_isClear) begin
                r_carry   <= 1'b0;
                r_zero    <= 1'b1;
                r_opCount <= '0;
            end
        end
    end

`ifdef ADDSUB_OVF_FLAG_EN
    logic r_ovf;
    logic w_ovf;

    // Signed overflow: operands agree in sign but the result sign differs.
    always_comb begin
        w_ovf = (w_x[WIDTH-1] == w_yEff[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_isArith) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.o_ovf = r_ovf;
`else
    assign bus.o_ovf = 1'b0;
`endif

    assign bus.o_acc         = r_acc;
    assign bus.o_carry       = r_carry;
    assign bus.o_zero        = r_zero;
    assign bus.o_result      = r_result;
    assign bus.o_resultValid = r_resultValid;
    assign bus.o_opCount     = r_opCount;
endmodule

// File: tb/tb_addsub_datapath.sv
// Self-checking bench for addsub_datapath: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_addsub_datapath;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    bit   checking;

    int mRa, mRb, mAcc, mCarry, mZero, mOvf, mResult, mValid, mCnt, mDoneQ;

    addsub_datapath_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    addsub_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [5:0] csWord(input bit en, input bit done, input int sel, input bit m);
        logic [2:0] s;
        s = 3'(sel);
        return {en, done, s, m};
    endfunction

    // Reference model: plain integer arithmetic on the architectural state.
    task automatic updateModel(input logic rst, input logic [5:0] c, input int a, input int b);
        int sel, x, y, full, sx, sy, sres;
        bit m;
        if (rst) begin
            mRa = 0; mRb = 0; mAcc = 0; mCarry = 0; mZero = 0; mOvf = 0;
            mResult = 0; mValid = 0; mCnt = 0; mDoneQ = 0;
            return;
        end
        sel = int'(c[3:1]);
        m   = c[0];
        if (c[5]) begin
            if (sel == 1) mRa = a;
            else if (sel == 2) mRb = b;
            else if (sel >= 3 && sel <= 5) begin
                x    = (sel == 3) ? mRa : mAcc;
                y    = (sel == 5) ? mRa : mRb;
                full = m ? (x - y + 256) : (x + y);
                mCarry = (full >= 256) ? 1 : 0;
                mAcc   = full % 256;
                mZero  = (mAcc == 0) ? 1 : 0;
                sx   = (x >= 128) ? x - 256 : x;
                sy   = (y >= 128) ? y - 256 : y;
                sres = m ? (sx - sy) : (sx + sy);
`ifdef ADDSUB_OVF_FLAG_EN
                mOvf = (sres > 127 || sres < -128) ? 1 : 0;
`else
                mOvf = 0;
                if (sres == 0) mOvf = 0;
`endif
                mCnt = (mCnt < 255) ? mCnt + 1 : 255;
            end else if (sel == 6) begin
                mAcc = 0; mCnt = 0; mCarry = 0; mZero = 1;
            end
        end
        if (c[4] && mDoneQ == 0) begin
            mValid  = 1;
            mResult = mAcc;
        end else begin
            mValid = 0;
        end
        mDoneQ = c[4] ? 1 : 0;
    endtask

    task automatic applyStimulus(input logic rst, input logic [5:0] c, input logic [7:0] a, input logic [7:0] b);
        reset       = rst;
        bus.i_cs    = c;
        bus.i_dataA = a;
        bus.i_dataB = b;
        @(posedge clock);
        updateModel(rst, c, int'(a), int'(b));
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clock) begin
        if (checking) begin
            checkOutput("cmpAcc",    int'(bus.o_acc),         mAcc);
            checkOutput("cmpCarry",  int'(bus.o_carry),       mCarry);
            checkOutput("cmpZero",   int'(bus.o_zero),        mZero);
            checkOutput("cmpResult", int'(bus.o_result),      mResult);
            checkOutput("cmpValid",  int'(bus.o_resultValid), mValid);
            checkOutput("cmpCount",  int'(bus.o_opCount),     mCnt);
            checkOutput("cmpOvf",    int'(bus.o_ovf),         mOvf);
        end
    end

    task automatic doReset();
        applyStimulus(1'b1, csWord(1, 1, 3, 0), 8'h00, 8'h00);
    endtask

    task automatic loadOps(input logic [7:0] a, input logic [7:0] b);
        applyStimulus(1'b0, csWord(1, 0, 1, 0), a, 8'h00);
        applyStimulus(1'b0, csWord(1, 0, 2, 0), 8'h00, b);
    endtask

    int expOvf;

    initial begin
        checks   = 0;
        errors   = 0;
        checking = 0;
        reset    = 1'b1;
        bus.i_cs = '0; bus.i_dataA = '0; bus.i_dataB = '0;
`ifdef ADDSUB_OVF_FLAG_EN
        expOvf = 1;
`else
        expOvf = 0;
`endif
        doReset();
        checking = 1;
        checkOutput("resetAcc", int'(bus.o_acc), 0);

        // Add 5 + 3, then reset mid-run with an arithmetic cs present
        loadOps(8'h05, 8'h03);
        checkOutput("loadCarry", int'(bus.o_carry), 0);
        applyStimulus(1'b0, csWord(1, 0, 3, 0), 8'h00, 8'h00);
        checkOutput("addAcc",   int'(bus.o_acc), 8'h08);
        checkOutput("addCarry", int'(bus.o_carry), 0);
        checkOutput("addZero",  int'(bus.o_zero), 0);
        checkOutput("addCount", int'(bus.o_opCount), 1);
        applyStimulus(1'b0, csWord(1, 0, 4, 0), 8'h00, 8'h00);
        applyStimulus(1'b0, csWord(1, 0, 4, 0), 8'h00, 8'h00);
        checkOutput("preRstCount", int'(bus.o_opCount), 3);
        doReset();
        checkOutput("rstAcc",   int'(bus.o_acc), 0);
        checkOutput("rstCount", int'(bus.o_opCount), 0);
        checkOutput("rstValid", int'(bus.o_resultValid), 0);

        // Subtract and borrow
        loadOps(8'h05, 8'h03);
        applyStimulus(1'b0, csWord(1, 0, 3, 1), 8'h00, 8'h00);
        checkOutput("subAcc",   int'(bus.o_acc), 8'h02);
        checkOutput("subCarry", int'(bus.o_carry), 1);
        applyStimulus(1'b0, csWord(1, 0, 4, 1), 8'h00, 8'h00);
        checkOutput("borrowAcc",   int'(bus.o_acc), 8'hFF);
        checkOutput("borrowCarry", int'(bus.o_carry), 0);
        applyStimulus(1'b0, csWord(1, 0, 4, 1), 8'h00, 8'h00);
        applyStimulus(1'b0, csWord(1, 0, 4, 1), 8'h00, 8'h00);
        checkOutput("subAcc3",  int'(bus.o_acc), 8'hF9);
        checkOutput("subCount", int'(bus.o_opCount), 4);

        // Wrap to zero, then clear
        loadOps(8'hFF, 8'h01);
        applyStimulus(1'b0, csWord(1, 0, 3, 0), 8'h00, 8'h00);
        checkOutput("wrapAcc",   int'(bus.o_acc), 0);
        checkOutput("wrapCarry", int'(bus.o_carry), 1);
        checkOutput("wrapZero",  int'(bus.o_zero), 1);
        applyStimulus(1'b0, csWord(1, 0, 6, 0), 8'h00, 8'h00);
        checkOutput("clrCount", int'(bus.o_opCount), 0);
        checkOutput("clrZero",  int'(bus.o_zero), 1);
        checkOutput("clrCarry", int'(bus.o_carry), 0);

        // Done edge captures the same-cycle ACC
        loadOps(8'h05, 8'h03);
        applyStimulus(1'b0, csWord(1, 1, 3, 0), 8'h00, 8'h00);
        checkOutput("doneResult", int'(bus.o_result), 8'h08);
        checkOutput("doneValid",  int'(bus.o_resultValid), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, csWord(0, 1, 0, 0), 8'h00, 8'h00);
            checkOutput("doneHeld", int'(bus.o_resultValid), 0);
        end
        applyStimulus(1'b0, csWord(0, 0, 0, 0), 8'h00, 8'h00);
        applyStimulus(1'b0, csWord(0, 1, 0, 0), 8'h00, 8'h00);
        checkOutput("done2Valid", int'(bus.o_resultValid), 1);
        applyStimulus(1'b0, csWord(0, 0, 3, 0), 8'h00, 8'h00);
        checkOutput("enOffAcc", int'(bus.o_acc), 8'h08);

        // Signed overflow
        loadOps(8'h7F, 8'h01);
        applyStimulus(1'b0, csWord(1, 0, 3, 0), 8'h00, 8'h00);
        checkOutput("ovfAddAcc", int'(bus.o_acc), 8'h80);
        checkOutput("ovfAdd",    int'(bus.o_ovf), expOvf);
        loadOps(8'h80, 8'h01);
        applyStimulus(1'b0, csWord(1, 0, 3, 1), 8'h00, 8'h00);
        checkOutput("ovfSubAcc", int'(bus.o_acc), 8'h7F);
        checkOutput("ovfSub",    int'(bus.o_ovf), expOvf);

        // Counter saturation
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, csWord(1, 0, 4, 0), 8'h00, 8'h00);
        end
        checkOutput("satCount", int'(bus.o_opCount), 255);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                          6'($urandom_range(0, 63)),
                          8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)));
        end

        checking = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
